// File: rtl/fifo_pkg.sv
// Shared helpers for both sides of the asynchronous FIFO: Gray/binary
// conversion and the minimum synchroniser depth.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int MAX_PTR_WIDTH   = 32;

  // Callers zero-extend their pointer to MAX_PTR_WIDTH and truncate the
  // result back, so a single function serves every PTR_WIDTH.
  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] gray);
    logic [MAX_PTR_WIDTH-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_PTR_WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Plain multi-flop synchroniser for a Gray-coded pointer crossing clock
// domains. Shared by the read and write controllers.
module fifo_ptr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_stage_check
    $error("fifo_ptr_sync: SYNC_STAGES below minimum");
  end

  logic [WIDTH-1:0] stages [SYNC_STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, empty/level
// generation and a registered valid/ready output stage fed from fifo_mem.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int PTR_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic [PTR_WIDTH-1:0]  w_gray_ptr,
  output logic [PTR_WIDTH-1:0]  r_gray_ptr,
  output logic [PTR_WIDTH-2:0]  r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  r_empty,
  output logic [PTR_WIDTH-1:0]  r_level
);

  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || (1 << (PTR_WIDTH - 1)) != FIFO_DEPTH) begin : g_param_check
    $error("fifo_rd_ctrl: FIFO_DEPTH must be a power of 2 and PTR_WIDTH = log2(FIFO_DEPTH)+1");
  end

  logic [PTR_WIDTH-1:0] r_bin_ptr;
  logic [PTR_WIDTH-1:0] r_bin_next;
  logic [PTR_WIDTH-1:0] wq_gray;
  logic [PTR_WIDTH-1:0] wq_bin;
  logic                 pop;

  fifo_ptr_sync #(
    .WIDTH       (PTR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk      (r_clk),
    .rstn     (r_rstn),
    .async_in (w_gray_ptr),
    .sync_out (wq_gray)
  );

  assign wq_bin     = PTR_WIDTH'(gray2bin(MAX_PTR_WIDTH'(wq_gray)));
  assign r_bin_next = r_bin_ptr + PTR_WIDTH'(1);

  // Gray compare is safe here: both operands are registered in this domain.
  assign r_empty = (r_gray_ptr == wq_gray);
  assign r_level = wq_bin - r_bin_ptr;
  assign r_addr  = r_bin_ptr[PTR_WIDTH-2:0];

  // Refill in the same cycle the consumer accepts, giving one word per clock.
  assign pop = !r_empty && (!out_valid || out_ready);

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_bin_ptr  <= '0;
      r_gray_ptr <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else if (pop) begin
      out_data   <= r_data;
      out_valid  <= 1'b1;
      r_bin_ptr  <= r_bin_next;
      r_gray_ptr <= PTR_WIDTH'(bin2gray(MAX_PTR_WIDTH'(r_bin_next)));
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small behavioural memory and a
// bench-driven write pointer.
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rstn;
  logic [3:0] w_gray_ptr;
  logic [3:0] r_gray_ptr;
  logic [2:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       r_empty;
  logic [3:0] r_level;

  logic [7:0] mem [8];
  logic [3:0] wptr;
  int         assertCount = 0;
  int         failCount   = 0;

  fifo_rd_ctrl #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (8),
    .PTR_WIDTH  (4),
    .SYNC_STAGES(2)
  ) dut (
    .r_clk      (r_clk),
    .r_rstn     (r_rstn),
    .w_gray_ptr (w_gray_ptr),
    .r_gray_ptr (r_gray_ptr),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r_empty    (r_empty),
    .r_level    (r_level)
  );

  always #5 r_clk = ~r_clk;

  // Combinational memory read, as fifo_mem would present it.
  assign r_data = mem[r_addr];

  function automatic logic [3:0] toGray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic setWptr(input logic [3:0] p);
    wptr       = p;
    w_gray_ptr = toGray(p);
  endtask

  task automatic applyStimulus();
    r_rstn    = 1'b0;
    out_ready = 1'b0;
    setWptr(4'd0);
    tick(2);
    r_rstn = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [3:0] prevGray;
    int         rdCount;
    int         burst [3];

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset with a nonzero write pointer: synchroniser must stay cleared.
    r_rstn     = 1'b0;
    out_ready  = 1'b0;
    w_gray_ptr = 4'b0011;
    tick(3);
    checkOutput("rst_empty", 32'(r_empty), 32'd1);
    checkOutput("rst_level", 32'(r_level), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_addr", 32'(r_addr), 32'd0);
    checkOutput("rst_gray", 32'(r_gray_ptr), 32'd0);

    // Single word with latency check.
    applyStimulus();
    mem[0] = 8'hA5;
    setWptr(4'd1);
    tick(1);
    checkOutput("single_empty_e1", 32'(r_empty), 32'd1);
    tick(1);
    checkOutput("single_empty_e2", 32'(r_empty), 32'd0);
    checkOutput("single_level_e2", 32'(r_level), 32'd1);
    checkOutput("single_valid_e2", 32'(out_valid), 32'd0);
    tick(1);
    checkOutput("single_valid_e3", 32'(out_valid), 32'd1);
    checkOutput("single_data_e3", 32'(out_data), 32'hA5);
    checkOutput("single_addr", 32'(r_addr), 32'd1);
    checkOutput("single_empty_e3", 32'(r_empty), 32'd1);
    tick(3);
    checkOutput("single_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("single_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick(1);
    checkOutput("single_accept", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Full-memory burst at one word per clock.
    applyStimulus();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    setWptr(4'd8);
    out_ready = 1'b1;
    tick(2);
    checkOutput("burst_level_full", 32'(r_level), 32'd8);
    checkOutput("burst_empty_full", 32'(r_empty), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("burst_valid", 32'(out_valid), 32'd1);
      checkOutput("burst_data", 32'(out_data), 32'h10 + 32'(i));
      checkOutput("burst_level", 32'(r_level), 32'(7 - i));
    end
    checkOutput("burst_gray_end", 32'(r_gray_ptr), 32'b1100);
    tick(1);
    checkOutput("burst_drained", 32'(out_valid), 32'd0);
    checkOutput("burst_empty_end", 32'(r_empty), 32'd1);
    out_ready = 1'b0;

    // Backpressure: output stage and pointer must freeze.
    applyStimulus();
    for (int i = 0; i < 4; i++) mem[i] = 8'h20 + 8'(i);
    setWptr(4'd4);
    tick(3);
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("bp_data_hold", 32'(out_data), 32'h20);
      checkOutput("bp_level_hold", 32'(r_level), 32'd3);
      checkOutput("bp_gray_hold", 32'(r_gray_ptr), 32'b0001);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick(1);
      checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_release_data", 32'(out_data), 32'h20 + 32'(i));
    end
    tick(1);
    checkOutput("bp_release_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Wrap-around across 20 words in bursts of 8, 8 and 4.
    applyStimulus();
    burst[0] = 8; burst[1] = 8; burst[2] = 4;
    rdCount  = 0;
    prevGray = r_gray_ptr;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < burst[b]; k++) begin
        mem[3'(wptr + 4'(k))] = 8'h40 + 8'(rdCount + k);
      end
      setWptr(wptr + 4'(burst[b]));
      tick(2);
      checkOutput("wrap_level", 32'(r_level), 32'(burst[b]));
      for (int k = 0; k < burst[b]; k++) begin
        checkOutput("wrap_addr", 32'(r_addr), 32'(rdCount % 8));
        tick(1);
        checkOutput("wrap_data", 32'(out_data), 32'h40 + 32'(rdCount));
        checkOutput("wrap_gray_step", 32'($countones(prevGray ^ r_gray_ptr)), 32'd1);
        prevGray = r_gray_ptr;
        rdCount++;
      end
    end
    checkOutput("wrap_gray_end", 32'(r_gray_ptr), 32'(toGray(4'd4)));
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a burst.
    applyStimulus();
    for (int i = 0; i < 8; i++) mem[i] = 8'h60 + 8'(i);
    setWptr(4'd8);
    tick(3);
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    checkOutput("midrst_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("midrst_pre_level", 32'(r_level), 32'd5);
    #2;
    r_rstn = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data", 32'(out_data), 32'd0);
    checkOutput("midrst_empty", 32'(r_empty), 32'd1);
    checkOutput("midrst_level", 32'(r_level), 32'd0);
    checkOutput("midrst_addr", 32'(r_addr), 32'd0);
    checkOutput("midrst_gray", 32'(r_gray_ptr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
